// File: rtl/ysyx_24080006_issue_ctrl.sv
// Issue controller: scoreboard hazard check, in-flight bound and
// drain-before-serialize sequencing in front of a single EXU output register.
module ysyx_24080006_issue_ctrl #(
  parameter int REG_WIDTH    = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in_rs1,
  input  logic [REG_WIDTH-1:0] in_rs2,
  input  logic [REG_WIDTH-1:0] in_rd,
  input  logic                 in_we,
  input  logic                 in_serial,
  input  logic                 in_fencei,
  input  logic                 in_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 ret_valid,
  input  logic                 ret_we,
  input  logic [REG_WIDTH-1:0] ret_rd,
  input  logic                 flush,
  output logic                 fencei_req,
  input  logic                 fencei_ack,
  output logic                 halt,
  output logic [3:0]           inflight
);

  localparam int NREG = 1 << REG_WIDTH;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    FENCE,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NREG-1:0]      pend;
  logic [NREG-1:0]      pend_nxt;
  logic [NREG-1:0]      ret_clr;
  logic [NREG-1:0]      eff_pend;
  logic [REG_WIDTH-1:0] out_rd;
  logic                 out_we;
  logic [3:0]           cnt;
  logic [3:0]           cnt_nxt;
  logic [3:0]           cnt_eff;
  logic [4:0]           cnt_sum;
  logic [1:0]           cnt_dec;
  logic                 ret_hit;
  logic                 kill;
  logic                 accept;
  logic                 hazard;
  logic                 drained;
  logic                 space;
  logic                 special;
  logic                 ready_norm;

  // A retire in this cycle frees its rd for the incoming instruction.
  always_comb begin
    ret_clr = '0;
    if (ret_valid && ret_we) ret_clr[ret_rd] = 1'b1;
  end

  assign eff_pend = pend & ~ret_clr;

  assign hazard = ((in_rs1 != '0) && eff_pend[in_rs1])
                | ((in_rs2 != '0) && eff_pend[in_rs2])
                | (in_we && (in_rd != '0) && eff_pend[in_rd]);

  assign ret_hit = ret_valid && (cnt != '0);
  assign cnt_eff = cnt - {3'b000, ret_hit};
  assign drained = (cnt == '0);
  assign space   = (cnt_eff < 4'(MAX_INFLIGHT))
                && (!out_valid || out_ready);
  assign special = in_valid && (in_serial || in_fencei || in_err);
  assign ready_norm = in_valid && !hazard && space;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) begin
          in_ready = 1'b0;
        end else if (special && !drained) begin
          state_nxt = DRAIN;
        end else if (in_valid && in_err) begin
          state_nxt = HALT;
        end else if (in_valid && in_fencei) begin
          state_nxt = FENCE;
        end else begin
          in_ready = ready_norm;
        end
      end
      DRAIN: begin
        if (flush) begin
          state_nxt = RUN;
        end else if (drained) begin
          if (in_valid && in_err)         state_nxt = HALT;
          else if (in_valid && in_fencei) state_nxt = FENCE;
          else                            state_nxt = RUN;
        end
      end
      FENCE: begin
        // fence.i is swallowed here; the ack cycle consumes it.
        if (fencei_ack) begin
          in_ready  = 1'b1;
          state_nxt = RUN;
        end
      end
      HALT: begin
        in_ready = 1'b0;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign accept = in_valid && in_ready && (state != FENCE);
  assign kill   = flush && out_valid && !out_ready && (state != FENCE);

  assign cnt_sum = {1'b0, cnt} + {4'b0000, accept};
  assign cnt_dec = {1'b0, ret_hit} + {1'b0, kill};

  always_comb begin
    if (cnt_sum >= {3'b000, cnt_dec})
      cnt_nxt = 4'(cnt_sum - {3'b000, cnt_dec});
    else
      cnt_nxt = '0;
  end

  // Set from a new accept beats a same-cycle clear of the same rd.
  always_comb begin
    pend_nxt = pend & ~ret_clr;
    if (kill && out_we) pend_nxt[out_rd] = 1'b0;
    if (accept && in_we && (in_rd != '0)) pend_nxt[in_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= RUN;
      pend      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      cnt   <= cnt_nxt;
      if (kill) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_rd    <= in_rd;
        out_we    <= in_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign fencei_req = reset_n && (state == FENCE);
  assign halt       = (state == HALT);
  assign inflight   = cnt;

  a_ret_underflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(ret_valid && (cnt == '0))
  );

endmodule

// File: tb/tb_ysyx_24080006_issue_ctrl.sv
// Directed bench for the issue controller: handshake, hazards,
// capacity, drain/fence/halt sequencing, flush and reset.
module tb_ysyx_24080006_issue_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic [4:0] in_rd;
  logic       in_we;
  logic       in_serial;
  logic       in_fencei;
  logic       in_err;
  logic       out_valid;
  logic       out_ready;
  logic       ret_valid;
  logic       ret_we;
  logic [4:0] ret_rd;
  logic       flush;
  logic       fencei_req;
  logic       fencei_ack;
  logic       halt;
  logic [3:0] inflight;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_24080006_issue_ctrl #(
    .REG_WIDTH(5),
    .MAX_INFLIGHT(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_rd(in_rd),
    .in_we(in_we),
    .in_serial(in_serial),
    .in_fencei(in_fencei),
    .in_err(in_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ret_valid(ret_valid),
    .ret_we(ret_we),
    .ret_rd(ret_rd),
    .flush(flush),
    .fencei_req(fencei_req),
    .fencei_ack(fencei_ack),
    .halt(halt),
    .inflight(inflight)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    in_serial = 1'b0;
    in_fencei = 1'b0;
    in_err    = 1'b0;
  endtask

  task automatic put(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we);
    idle();
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_we    = we;
  endtask

  task automatic ret(input logic v, input logic [4:0] rd);
    ret_valid = v;
    ret_we    = v;
    ret_rd    = rd;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (fencei_req !== 1'b0) begin n_bad++; $display("FAIL rst_fencei_req got %b want 0", fencei_req); end
    n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt got %b want 0", halt); end
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL rst_inflight got %0d want 0", inflight); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    put(0, 0, 1, 1); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy0 got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ov0 got %b want 1", out_valid); end
    put(0, 0, 2, 1); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy1 got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ov1 got %b want 1", out_valid); end
    n_cmp++; if (inflight !== 4'd2) begin n_bad++; $display("FAIL b2b_cnt2 got %0d want 2", inflight); end
    idle(); ret(1, 1); tick();
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL b2b_cnt1 got %0d want 1", inflight); end
    ret(1, 2); tick(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL b2b_cnt0 got %0d want 0", inflight); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ov_end got %b want 0", out_valid); end
  endtask

  task automatic test_raw();
    out_ready = 1'b1;
    put(0, 0, 5, 1); tick();
    put(5, 0, 6, 1); settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall0 got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall1 got %b want 0", in_ready); end
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL raw_cnt got %0d want 1", inflight); end
    ret(1, 5); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass got %b want 1", in_ready); end
    tick(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL raw_cnt_after got %0d want 1", inflight); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL raw_ov got %b want 1", out_valid); end
    put(5, 0, 0, 0); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_p5_clear got %b want 1", in_ready); end
    put(6, 0, 0, 0); settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_p6_set got %b want 0", in_ready); end
    idle(); ret(1, 6); tick(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL raw_cnt_end got %0d want 0", inflight); end
  endtask

  task automatic test_capacity();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(0, 0, 5'(i), 1); settle();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL cap_acc%0d got %b want 1", i, in_ready); end
      tick();
    end
    n_cmp++; if (inflight !== 4'd4) begin n_bad++; $display("FAIL cap_cnt4 got %0d want 4", inflight); end
    put(0, 0, 8, 1); settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL cap_full got %b want 0", in_ready); end
    tick();
    n_cmp++; if (inflight !== 4'd4) begin n_bad++; $display("FAIL cap_hold got %0d want 4", inflight); end
    ret(1, 1); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL cap_ret_acc got %b want 1", in_ready); end
    tick(); idle(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd4) begin n_bad++; $display("FAIL cap_cnt_stay got %0d want 4", inflight); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL cap_ov got %b want 1", out_valid); end
    ret(1, 2); tick(); ret(1, 3); tick(); ret(1, 4); tick(); ret(1, 8); tick(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL cap_cnt_end got %0d want 0", inflight); end
  endtask

  task automatic test_fencei();
    out_ready = 1'b1;
    put(0, 0, 1, 1); tick();
    put(0, 0, 2, 1); tick();
    idle(); in_valid = 1'b1; in_fencei = 1'b1; settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fen_stall got %b want 0", in_ready); end
    tick();
    n_cmp++; if (fencei_req !== 1'b0) begin n_bad++; $display("FAIL fen_req_drain got %b want 0", fencei_req); end
    ret(1, 1); tick(); ret(1, 2); tick(); ret(0, 0);
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL fen_drained got %0d want 0", inflight); end
    tick();
    n_cmp++; if (fencei_req !== 1'b1) begin n_bad++; $display("FAIL fen_req_on got %b want 1", fencei_req); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fen_wait_rdy got %b want 0", in_ready); end
    tick();
    fencei_ack = 1'b1; settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fen_ack_rdy got %b want 1", in_ready); end
    tick(); fencei_ack = 1'b0; idle();
    n_cmp++; if (fencei_req !== 1'b0) begin n_bad++; $display("FAIL fen_req_off got %b want 0", fencei_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fen_ov got %b want 0", out_valid); end
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL fen_cnt got %0d want 0", inflight); end
  endtask

  task automatic test_serial();
    out_ready = 1'b1;
    put(0, 0, 3, 1); tick();
    put(0, 0, 4, 1); in_serial = 1'b1; settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ser_stall got %b want 0", in_ready); end
    tick(); ret(1, 3); tick(); ret(0, 0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ser_drain got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ser_issue got %b want 1", in_ready); end
    tick(); idle();
    n_cmp++; if (inflight !== 4'd1) begin n_bad++; $display("FAIL ser_cnt got %0d want 1", inflight); end
    ret(1, 4); tick(); ret(0, 0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    put(0, 0, 7, 1); tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fl_ov_pre got %b want 1", out_valid); end
    put(0, 0, 9, 1); flush = 1'b1; settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_rdy got %b want 0", in_ready); end
    tick(); flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_ov got %b want 0", out_valid); end
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL fl_cnt got %0d want 0", inflight); end
    put(7, 0, 7, 1); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_p7_clear got %b want 1", in_ready); end
    idle(); out_ready = 1'b1;
  endtask

  task automatic test_halt();
    out_ready = 1'b1;
    put(0, 0, 3, 1); tick();
    idle(); in_valid = 1'b1; in_err = 1'b1; settle();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hlt_stall got %b want 0", in_ready); end
    tick();
    n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL hlt_early got %b want 0", halt); end
    ret(1, 3); tick(); ret(0, 0);
    n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL hlt_wait got %b want 0", halt); end
    tick();
    n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL hlt_set got %b want 1", halt); end
    idle(); put(0, 0, 1, 1); tick(); tick();
    n_cmp++; if (halt !== 1'b1) begin n_bad++; $display("FAIL hlt_sticky got %b want 1", halt); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hlt_rdy got %b want 0", in_ready); end
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL hlt_cnt got %0d want 0", inflight); end
    idle(); reset_n = 1'b0; tick(); reset_n = 1'b1;
    n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL hlt_rst got %b want 0", halt); end
    put(0, 0, 1, 1); settle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hlt_run got %b want 1", in_ready); end
    idle();
  endtask

  task automatic test_reset_in_fence();
    idle(); in_valid = 1'b1; in_fencei = 1'b1; tick();
    n_cmp++; if (fencei_req !== 1'b1) begin n_bad++; $display("FAIL rf_req got %b want 1", fencei_req); end
    reset_n = 1'b0; settle();
    n_cmp++; if (fencei_req !== 1'b0) begin n_bad++; $display("FAIL rf_req_drop got %b want 0", fencei_req); end
    tick(); idle(); reset_n = 1'b1; tick();
    n_cmp++; if (fencei_req !== 1'b0) begin n_bad++; $display("FAIL rf_req_after got %b want 0", fencei_req); end
    n_cmp++; if (inflight !== 4'd0) begin n_bad++; $display("FAIL rf_cnt got %0d want 0", inflight); end
  endtask

  initial begin
    reset_n    = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    fencei_ack = 1'b0;
    idle();
    ret(0, 0);
    tick();
    tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_back_to_back();
    test_raw();
    test_capacity();
    test_fencei();
    test_serial();
    test_flush();
    test_halt();
    test_reset_in_fence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
